// File: rtl/fmul_rr_sched_if.sv
// Signal bundle between fmul_rr_sched, its N_REQ requesters and the shared fmul.
// The scheduler takes the slave view; the requesters plus fmul together form the master side.
interface fmul_rr_sched_if #(
  parameter int N_REQ = 4
) ();
  logic [N_REQ-1:0]    req;
  logic [16*N_REQ-1:0] req_a;
  logic [16*N_REQ-1:0] req_b;
  logic [N_REQ-1:0]    resp_valid;
  logic [15:0]         resp_f;
  logic                resp_v;
  logic                resp_err;
  logic                busy;
  logic [2:0]          grant_id;
  logic                mul_reset;
  logic                mul_enable;
  logic [15:0]         mul_f1;
  logic [15:0]         mul_f2;
  logic                mul_done;
  logic                mul_v;
  logic [15:0]         mul_f;

  modport slave (
    input  req, req_a, req_b, mul_done, mul_v, mul_f,
    output resp_valid, resp_f, resp_v, resp_err, busy, grant_id,
           mul_reset, mul_enable, mul_f1, mul_f2
  );

  modport master (
    output req, req_a, req_b, mul_done, mul_v, mul_f,
    input  resp_valid, resp_f, resp_v, resp_err, busy, grant_id,
           mul_reset, mul_enable, mul_f1, mul_f2
  );
endinterface

// File: rtl/fmul_rr_sched.sv
// Round-robin scheduler sharing one FP16 fmul among N_REQ requesters.
// Define FMUL_SAT_EN to return a signed +/-65504 result on overflow instead of zero.
module fmul_rr_sched #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 64,
  parameter int CLR_CYC = 2
) (
  input  logic           clk,
  input  logic           reset,
  fmul_rr_sched_if.slave bus
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int CW = $clog2(CLR_CYC + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CLR_LAST  = CW'(CLR_CYC - 1);

  typedef enum logic [2:0] {CLR, IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                 state;
  logic [IW-1:0]          rr_ptr;
  logic [IW-1:0]          gnt;
  logic [WW-1:0]          wait_cnt;
  logic [CW-1:0]          clr_cnt;
  logic [N_REQ-1:0]       resp_valid_r;
  logic [15:0]            resp_f_r;
  logic                   resp_v_r;
  logic                   resp_err_r;
  logic                   busy_r;
  logic                   mul_reset_r;
  logic                   mul_enable_r;
  logic [15:0]            mul_f1_r;
  logic [15:0]            mul_f2_r;
  logic [N_REQ-1:0][15:0] a_vec;
  logic [N_REQ-1:0][15:0] b_vec;
  logic                   pick_any;
  logic [IW-1:0]          pick_idx;
  logic                   wait_exit;
  logic [15:0]            exit_f;
  logic                   exit_v;
  logic                   exit_err;
  logic [15:0]            ovf_f;

  assign a_vec = bus.req_a;
  assign b_vec = bus.req_b;

`ifdef FMUL_SAT_EN
  assign ovf_f = {mul_f1_r[15] ^ mul_f2_r[15], 15'h7BFF};
`else
  assign ovf_f = 16'h0000;
`endif

  // Scan downwards so the candidate closest after rr_ptr is the one that sticks.
  always_comb begin
    pick_any = 1'b0;
    pick_idx = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (bus.req[IW'((int'(rr_ptr) + k) % N_REQ)]) begin
        pick_any = 1'b1;
        pick_idx = IW'((int'(rr_ptr) + k) % N_REQ);
      end
    end
  end

  always_comb begin
    wait_exit = 1'b1;
    exit_f    = 16'h0000;
    exit_v    = 1'b0;
    exit_err  = 1'b0;
    if (bus.mul_done) begin
      exit_f = bus.mul_f;
    end else if (bus.mul_v) begin
      exit_v = 1'b1;
      exit_f = ovf_f;
    end else if (wait_cnt == WAIT_LAST) begin
      exit_err = 1'b1;
    end else begin
      wait_exit = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= CLR;
      clr_cnt      <= '0;
      mul_reset_r  <= 1'b1;
      rr_ptr       <= IW'(N_REQ - 1);
      gnt          <= '0;
      wait_cnt     <= '0;
      resp_valid_r <= '0;
      resp_f_r     <= 16'h0000;
      resp_v_r     <= 1'b0;
      resp_err_r   <= 1'b0;
      mul_enable_r <= 1'b0;
      mul_f1_r     <= 16'h0000;
      mul_f2_r     <= 16'h0000;
      busy_r       <= 1'b1;
    end else begin
      case (state)
        CLR: begin
          if (clr_cnt == CLR_LAST) begin
            mul_reset_r <= 1'b0;
            busy_r      <= 1'b0;
            state       <= IDLE;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        IDLE: begin
          if (pick_any) begin
            gnt          <= pick_idx;
            rr_ptr       <= pick_idx;
            mul_f1_r     <= a_vec[pick_idx];
            mul_f2_r     <= b_vec[pick_idx];
            mul_enable_r <= 1'b1;
            busy_r       <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          mul_enable_r <= 1'b0;
          wait_cnt     <= '0;
          state        <= WAIT;
        end
        WAIT: begin
          if (wait_exit) begin
            resp_valid_r <= N_REQ'(1) << gnt;
            resp_f_r     <= exit_f;
            resp_v_r     <= exit_v;
            resp_err_r   <= exit_err;
            state        <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: begin
          resp_valid_r <= '0;
          resp_f_r     <= 16'h0000;
          resp_v_r     <= 1'b0;
          resp_err_r   <= 1'b0;
          mul_reset_r  <= 1'b1;
          clr_cnt      <= '0;
          state        <= CLR;
        end
        default: begin
          mul_reset_r <= 1'b1;
          clr_cnt     <= '0;
          state       <= CLR;
        end
      endcase
    end
  end

  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_f     = resp_f_r;
  assign bus.resp_v     = resp_v_r;
  assign bus.resp_err   = resp_err_r;
  assign bus.busy       = busy_r;
  assign bus.grant_id   = 3'(gnt);
  assign bus.mul_reset  = mul_reset_r;
  assign bus.mul_enable = mul_enable_r;
  assign bus.mul_f1     = mul_f1_r;
  assign bus.mul_f2     = mul_f2_r;
endmodule

// File: tb/tb_fmul_rr_sched.sv
// Scoreboard bench for fmul_rr_sched with a behavioural fmul stand-in.
// Honours FMUL_SAT_EN when computing overflow results.
module tb_fmul_rr_sched;
  localparam int N_REQ   = 4;
  localparam int TIMEOUT = 64;
  localparam int CLR_CYC = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;

  fmul_rr_sched_if #(.N_REQ(N_REQ)) bus ();

  fmul_rr_sched #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT), .CLR_CYC(CLR_CYC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] f;
    logic        v;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  exp_t        monE;
  int          compareCnt = 0;
  int          mismatchCnt = 0;
  int          lastGrant = N_REQ - 1;
  logic [15:0] opA[N_REQ];
  logic [15:0] opB[N_REQ];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compareCnt++;
    if (actual !== expected) begin
      mismatchCnt++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // The fmul stand-in: 0x7E00 as operand A hangs it, two huge magnitudes overflow it.
  function automatic logic [15:0] fmulFunc(input logic [15:0] a, input logic [15:0] b);
    return a ^ {b[7:0], b[15:8]} ^ 16'h5A5A;
  endfunction

  function automatic bit isHang(input logic [15:0] a);
    return a == 16'h7E00;
  endfunction

  function automatic bit isOvf(input logic [15:0] a, input logic [15:0] b);
    return !isHang(a) && (a[14:0] >= 15'h7800) && (b[14:0] >= 15'h7800);
  endfunction

  function automatic exp_t expectFor(input int idx);
    exp_t e;
    e.idx = idx;
    e.a   = opA[idx];
    e.b   = opB[idx];
    e.f   = 16'h0000;
    e.v   = 1'b0;
    e.err = 1'b0;
    if (isHang(e.a)) begin
      e.err = 1'b1;
    end else if (isOvf(e.a, e.b)) begin
      e.v = 1'b1;
`ifdef FMUL_SAT_EN
      e.f = {e.a[15] ^ e.b[15], 15'h7BFF};
`endif
    end else begin
      e.f = fmulFunc(e.a, e.b);
    end
    return e;
  endfunction

  function automatic int rrPick(input logic [N_REQ-1:0] mask);
    for (int k = 1; k <= N_REQ; k++) begin
      if (mask[(lastGrant + k) % N_REQ]) return (lastGrant + k) % N_REQ;
    end
    return -1;
  endfunction

  logic [15:0] fa = 16'h0000;
  logic [15:0] fb = 16'h0000;
  int          lat = 0;
  bit          running = 1'b0;

  always @(posedge clk) begin
    if (!reset || bus.mul_reset) begin
      bus.mul_done <= 1'b0;
      bus.mul_v    <= 1'b0;
      bus.mul_f    <= 16'h0000;
      running      <= 1'b0;
    end else if (bus.mul_enable) begin
      fa      <= bus.mul_f1;
      fb      <= bus.mul_f2;
      lat     <= int'($urandom_range(0, 4));
      running <= 1'b1;
    end else if (running) begin
      if (lat == 0) begin
        running <= 1'b0;
        if (!isHang(fa)) begin
          if (isOvf(fa, fb)) begin
            bus.mul_v <= 1'b1;
            bus.mul_f <= 16'h7C00;
          end else begin
            bus.mul_done <= 1'b1;
            bus.mul_f    <= fmulFunc(fa, fb);
          end
        end
      end else begin
        lat <= lat - 1;
      end
    end
  end

  int cyc = 0;
  int issueCyc = 0;
  int clrRun = 0;
  bit prevEn = 1'b0;
  bit prevResp = 1'b0;

  // Monitor: pops the scoreboard on every response and watches the fmul-side protocol.
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      clrRun   = 0;
      prevEn   = 1'b0;
      prevResp = 1'b0;
    end else begin
      if (bus.mul_reset) begin
        clrRun++;
      end else if (clrRun != 0) begin
        checkOutput("mul_reset_len", clrRun, CLR_CYC);
        clrRun = 0;
      end
      if (bus.mul_enable) begin
        checkOutput("enable_pulse", 32'(prevEn), 0);
        issueCyc = cyc;
        if (sb.size() > 0) begin
          checkOutput("mul_f1", 32'(bus.mul_f1), 32'(sb[0].a));
          checkOutput("mul_f2", 32'(bus.mul_f2), 32'(sb[0].b));
        end
      end
      prevEn = bus.mul_enable;
      if (prevResp) begin
        checkOutput("resp_clear_valid", 32'(bus.resp_valid), 0);
        checkOutput("resp_clear_f", 32'(bus.resp_f), 0);
        checkOutput("resp_clear_flags", {30'd0, bus.resp_v, bus.resp_err}, 0);
      end
      prevResp = (bus.resp_valid != '0);
      if (bus.resp_valid != '0) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_resp", 32'(bus.resp_valid), 0);
        end else begin
          monE = sb.pop_front();
          checkOutput("resp_valid", 32'(bus.resp_valid), 1 << monE.idx);
          checkOutput("grant_id", 32'(bus.grant_id), monE.idx);
          checkOutput("resp_f", 32'(bus.resp_f), 32'(monE.f));
          checkOutput("resp_v", 32'(bus.resp_v), 32'(monE.v));
          checkOutput("resp_err", 32'(bus.resp_err), 32'(monE.err));
          if (monE.err) checkOutput("timeout_latency", cyc - issueCyc, TIMEOUT + 1);
        end
      end
    end
  end

  task automatic loadOperands();
    for (int i = 0; i < N_REQ; i++) begin
      bus.req_a[16*i +: 16] = opA[i];
      bus.req_b[16*i +: 16] = opB[i];
    end
  endtask

  task automatic randOperands();
    int r;
    for (int i = 0; i < N_REQ; i++) begin
      r = int'($urandom_range(0, 19));
      if (r == 0) begin
        opA[i] = 16'h7E00;
        opB[i] = 16'($urandom);
      end else if (r <= 3) begin
        opA[i] = {1'($urandom_range(0, 1)), 15'h7800 | 15'($urandom_range(0, 1023))};
        opB[i] = {1'($urandom_range(0, 1)), 15'h7800 | 15'($urandom_range(0, 1023))};
      end else begin
        opA[i] = 16'($urandom) & 16'hBFFF;
        opB[i] = 16'($urandom) & 16'hBFFF;
      end
    end
  endtask

  // Sticky requesters raise their line again one cycle after being served.
  task automatic applyStimulus(input logic [N_REQ-1:0] mask, input int ops, input bit sticky);
    logic [N_REQ-1:0] live;
    logic [N_REQ-1:0] reraise;
    int served;
    int cycles;
    int g;
    live = mask;
    for (int n = 0; n < ops; n++) begin
      g = rrPick(live);
      if (g >= 0) begin
        sb.push_back(expectFor(g));
        lastGrant = g;
        if (!sticky) live = live & ~(N_REQ'(1) << g);
      end
    end
    loadOperands();
    bus.req = mask;
    served  = 0;
    cycles  = 0;
    reraise = '0;
    while (served < ops && cycles < ops * 100 + 50) begin
      @(negedge clk);
      cycles++;
      bus.req = bus.req | reraise;
      reraise = '0;
      if (bus.resp_valid != '0) begin
        served++;
        bus.req = bus.req & ~bus.resp_valid;
        if (sticky) reraise = bus.resp_valid;
      end
    end
    bus.req = '0;
    checkOutput("batch_served", served, ops);
    repeat (2) @(negedge clk);
  endtask

  task automatic waitEnable(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = bus.mul_enable;
    end
  endtask

  initial begin
    bit seen;
    logic [N_REQ-1:0] mask;
    bus.req   = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_mul_reset", 32'(bus.mul_reset), 1);
    checkOutput("rst_busy", 32'(bus.busy), 1);
    checkOutput("rst_resp_valid", 32'(bus.resp_valid), 0);
    checkOutput("rst_mul_enable", 32'(bus.mul_enable), 0);
    checkOutput("rst_grant_id", 32'(bus.grant_id), 0);
    checkOutput("rst_mul_f1", 32'(bus.mul_f1), 0);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("idle_busy", 32'(bus.busy), 0);
    checkOutput("idle_mul_reset", 32'(bus.mul_reset), 0);
    checkOutput("idle_resp_valid", 32'(bus.resp_valid), 0);

    for (int i = 0; i < N_REQ; i++) begin
      opA[i] = 16'($urandom) & 16'hBFFF;
      opB[i] = 16'($urandom) & 16'hBFFF;
    end
    applyStimulus(4'b1111, 5, 1'b1);

    opA[0] = 16'h3C00;
    opB[0] = 16'h4000;
    applyStimulus(4'b0001, 1, 1'b0);

    opA[2] = 16'hF800;
    opB[2] = 16'h7800;
    opA[3] = 16'h7800;
    opB[3] = 16'h7800;
    applyStimulus(4'b1100, 2, 1'b0);

    opA[1] = 16'h7E00;
    opB[1] = 16'h1234;
    applyStimulus(4'b0010, 1, 1'b0);

    // Requester drops its line after the grant; the op must still be answered.
    opA[1] = 16'h2A55;
    opB[1] = 16'h0F0F;
    loadOperands();
    sb.push_back(expectFor(rrPick(4'b0010)));
    lastGrant = 1;
    bus.req = 4'b0010;
    waitEnable(seen);
    checkOutput("drop_issue_seen", 32'(seen), 1);
    bus.req = '0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = (bus.resp_valid != '0);
    end
    checkOutput("drop_served", 32'(seen), 1);
    repeat (3) @(negedge clk);

    // Reset during WAIT abandons the op without a response.
    opA[0] = 16'h7E00;
    opB[0] = 16'h0001;
    loadOperands();
    bus.req = 4'b0001;
    waitEnable(seen);
    checkOutput("rst_mid_issue_seen", 32'(seen), 1);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("rst_mid_resp_valid", 32'(bus.resp_valid), 0);
    checkOutput("rst_mid_mul_reset", 32'(bus.mul_reset), 1);
    checkOutput("rst_mid_busy", 32'(bus.busy), 1);
    bus.req   = '0;
    lastGrant = N_REQ - 1;
    sb.delete();
    repeat (3) @(negedge clk);
    checkOutput("rst_mid_hold_valid", 32'(bus.resp_valid), 0);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (4) @(negedge clk);
    opA[0] = 16'h3800;
    opB[0] = 16'h3400;
    applyStimulus(4'b0001, 1, 1'b0);

    for (int n = 0; n < 40; n++) begin
      randOperands();
      mask = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
      applyStimulus(mask, $countones(mask), 1'b0);
    end

    repeat (5) @(negedge clk);
    checkOutput("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCnt, mismatchCnt);
    $finish;
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached, compared %0d", compareCnt);
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
